// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: forwarding selects, load-use/multi-cycle stalls,
// taken-branch flush window. Define HAZ_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LAT     = 1,
    parameter int MULTI_LAT    = 4,
    parameter int BRANCH_FLUSH = 0,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] addr_rs_id,
    input  logic [REG_ADDR_W-1:0] addr_rt_id,
    input  logic                  rs_used_id,
    input  logic                  rt_used_id,
    input  logic                  is_store_id,
    input  logic                  is_multi_id,
    input  logic                  branch_taken_id,
    input  logic                  wb_wen_exe,
    input  logic [REG_ADDR_W-1:0] regw_addr_exe,
    input  logic                  mem_ren_exe,
    input  logic                  wb_wen_mem,
    input  logic [REG_ADDR_W-1:0] regw_addr_mem,
    input  logic                  mem_ren_mem,
    input  logic                  wb_wen_wb,
    input  logic [REG_ADDR_W-1:0] regw_addr_wb,
    output logic [2:0]            fwd_a_ctrl,
    output logic [2:0]            fwd_b_ctrl,
    output logic                  fwd_m,
    output logic                  if_en,
    output logic                  id_en,
    output logic                  exe_en,
    output logic                  mem_en,
    output logic                  wb_en,
    output logic                  if_rst,
    output logic                  id_rst,
    output logic                  exe_rst,
    output logic                  mem_rst,
    output logic                  wb_rst,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_load_cnt,
    output logic [CNT_W-1:0]      stall_multi_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, MULTI_BUSY, FLUSH} state_t;

    localparam logic [3:0] LOAD_CNT  = 4'(LOAD_LAT - 1);
    localparam logic [3:0] MULTI_CNT = 4'(MULTI_LAT - 1);
    localparam logic [3:0] FLUSH_CNT = 4'(BRANCH_FLUSH);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;

    // First match wins: a load still in EXE cannot forward, so it falls through to older stages.
    function automatic logic [2:0] fwd_sel(input logic used, input logic [REG_ADDR_W-1:0] a);
        if (!used || a == '0)                                       return 3'b000;
        else if (wb_wen_exe && !mem_ren_exe && a == regw_addr_exe) return 3'b001;
        else if (wb_wen_mem && mem_ren_mem && a == regw_addr_mem)  return 3'b011;
        else if (wb_wen_mem && a == regw_addr_mem)                 return 3'b010;
        else if (wb_wen_wb && a == regw_addr_wb)                   return 3'b100;
        else                                                       return 3'b000;
    endfunction

    assign fwd_a_ctrl = fwd_sel(rs_used_id, addr_rs_id);
    assign fwd_b_ctrl = fwd_sel(rt_used_id, addr_rt_id);
    assign fwd_m      = is_store_id && mem_ren_exe && addr_rt_id != '0 && addr_rt_id == regw_addr_exe;

    // Store data comes from the MEM-stage load via fwd_m, so a store's rt never causes a stall.
    assign load_use = mem_ren_exe && regw_addr_exe != '0 &&
                      ((rs_used_id && addr_rs_id == regw_addr_exe) ||
                       (rt_used_id && !is_store_id && addr_rt_id == regw_addr_exe));

    assign busy = (state_q != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if_en   = 1'b1;
        id_en   = 1'b1;
        exe_en  = 1'b1;
        mem_en  = 1'b1;
        wb_en   = 1'b1;
        if_rst  = 1'b0;
        id_rst  = 1'b0;
        exe_rst = 1'b0;
        mem_rst = 1'b0;
        wb_rst  = 1'b0;
        case (state_q)
            RUN: begin
                if (load_use) begin
                    if_en   = 1'b0;
                    id_en   = 1'b0;
                    exe_rst = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = LOAD_CNT;
                    end
                end else if (is_multi_id && MULTI_LAT > 1) begin
                    state_d = MULTI_BUSY;
                    cnt_d   = MULTI_CNT;
                end else if (branch_taken_id && BRANCH_FLUSH > 0) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_CNT;
                end
            end
            LOAD_STALL: begin
                if_en   = 1'b0;
                id_en   = 1'b0;
                exe_rst = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RUN;
            end
            MULTI_BUSY: begin
                if_en   = 1'b0;
                id_en   = 1'b0;
                exe_en  = 1'b0;
                mem_rst = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RUN;
            end
            FLUSH: begin
                id_rst = 1'b1;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
        if (rst) begin
            {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b11111;
            {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_load_cnt_q, stall_multi_cnt_q, flush_cnt_q;
    logic             load_inc, multi_inc, flush_inc;

    assign load_inc  = (state_q == RUN && load_use) || state_q == LOAD_STALL;
    assign multi_inc = (state_q == MULTI_BUSY);
    assign flush_inc = (state_q == FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_load_cnt_q  <= '0;
            stall_multi_cnt_q <= '0;
            flush_cnt_q       <= '0;
        end else begin
            if (load_inc && stall_load_cnt_q != '1)   stall_load_cnt_q  <= stall_load_cnt_q + 1'b1;
            if (multi_inc && stall_multi_cnt_q != '1) stall_multi_cnt_q <= stall_multi_cnt_q + 1'b1;
            if (flush_inc && flush_cnt_q != '1)       flush_cnt_q       <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_load_cnt  = stall_load_cnt_q;
    assign stall_multi_cnt = stall_multi_cnt_q;
    assign flush_cnt       = flush_cnt_q;
`else
    assign stall_load_cnt  = '0;
    assign stall_multi_cnt = '0;
    assign flush_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with LOAD_LAT=2/BRANCH_FLUSH=2, one with defaults and
// a 4-bit counter width for the delay-slot and saturation cases.
module tb_pipe_hazard_ctrl;

    localparam bit PERF =
`ifdef HAZ_PERF_CNT_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] addr_rs_id, addr_rt_id, regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic rs_used_id, rt_used_id, is_store_id, is_multi_id, branch_taken_id;
    logic wb_wen_exe, mem_ren_exe, wb_wen_mem, mem_ren_mem, wb_wen_wb;

    logic [2:0]  fwd_a_ctrl, fwd_b_ctrl;
    logic        fwd_m, if_en, id_en, exe_en, mem_en, wb_en;
    logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst, busy;
    logic [31:0] stall_load_cnt, stall_multi_cnt, flush_cnt;

    logic [2:0] z_fwd_a, z_fwd_b;
    logic       z_fwd_m, z_if_en, z_id_en, z_exe_en, z_mem_en, z_wb_en;
    logic       z_if_rst, z_id_rst, z_exe_rst, z_mem_rst, z_wb_rst, z_busy;
    logic [3:0] z_stall_load_cnt, z_stall_multi_cnt, z_flush_cnt;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(2), .MULTI_LAT(4), .BRANCH_FLUSH(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .is_store_id(is_store_id), .is_multi_id(is_multi_id), .branch_taken_id(branch_taken_id),
        .wb_wen_exe(wb_wen_exe), .regw_addr_exe(regw_addr_exe), .mem_ren_exe(mem_ren_exe),
        .wb_wen_mem(wb_wen_mem), .regw_addr_mem(regw_addr_mem), .mem_ren_mem(mem_ren_mem),
        .wb_wen_wb(wb_wen_wb), .regw_addr_wb(regw_addr_wb),
        .fwd_a_ctrl(fwd_a_ctrl), .fwd_b_ctrl(fwd_b_ctrl), .fwd_m(fwd_m),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .busy(busy), .stall_load_cnt(stall_load_cnt), .stall_multi_cnt(stall_multi_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .MULTI_LAT(4), .BRANCH_FLUSH(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst),
        .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .is_store_id(is_store_id), .is_multi_id(is_multi_id), .branch_taken_id(branch_taken_id),
        .wb_wen_exe(wb_wen_exe), .regw_addr_exe(regw_addr_exe), .mem_ren_exe(mem_ren_exe),
        .wb_wen_mem(wb_wen_mem), .regw_addr_mem(regw_addr_mem), .mem_ren_mem(mem_ren_mem),
        .wb_wen_wb(wb_wen_wb), .regw_addr_wb(regw_addr_wb),
        .fwd_a_ctrl(z_fwd_a), .fwd_b_ctrl(z_fwd_b), .fwd_m(z_fwd_m),
        .if_en(z_if_en), .id_en(z_id_en), .exe_en(z_exe_en), .mem_en(z_mem_en), .wb_en(z_wb_en),
        .if_rst(z_if_rst), .id_rst(z_id_rst), .exe_rst(z_exe_rst), .mem_rst(z_mem_rst), .wb_rst(z_wb_rst),
        .busy(z_busy), .stall_load_cnt(z_stall_load_cnt), .stall_multi_cnt(z_stall_multi_cnt),
        .flush_cnt(z_flush_cnt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        addr_rs_id = 5'd0; addr_rt_id = 5'd0; rs_used_id = 1'b0; rt_used_id = 1'b0;
        is_store_id = 1'b0; is_multi_id = 1'b0; branch_taken_id = 1'b0;
        wb_wen_exe = 1'b0; regw_addr_exe = 5'd0; mem_ren_exe = 1'b0;
        wb_wen_mem = 1'b0; regw_addr_mem = 5'd0; mem_ren_mem = 1'b0;
        wb_wen_wb = 1'b0; regw_addr_wb = 5'd0;
    endtask

    task automatic do_reset;
        clear_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        clear_in();
        rst = 1'b1;
        #2;
        checks++; if ({if_rst, id_rst, exe_rst, mem_rst, wb_rst} !== 5'b11111) begin
            errors++; $display("FAIL reset_rsts: got %b expected 11111", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}); end
        checks++; if ({if_en, id_en, exe_en, mem_en, wb_en} !== 5'b11111) begin
            errors++; $display("FAIL reset_ens: got %b expected 11111", {if_en, id_en, exe_en, mem_en, wb_en}); end
        checks++; if ({busy, z_busy} !== 2'b00) begin
            errors++; $display("FAIL reset_busy: got %b expected 00", {busy, z_busy}); end
        checks++; if ({stall_load_cnt, stall_multi_cnt, flush_cnt} !== 96'd0) begin
            errors++; $display("FAIL reset_cnts: got %0h %0h %0h expected 0", stall_load_cnt, stall_multi_cnt, flush_cnt); end
        step();
        rst = 1'b0;
        #1;
        checks++; if ({if_rst, id_rst, exe_rst, mem_rst, wb_rst} !== 5'b00000) begin
            errors++; $display("FAIL post_reset_rsts: got %b expected 00000", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}); end
    endtask

    task automatic test_forward;
        do_reset();
        wb_wen_exe = 1'b1; regw_addr_exe = 5'd3;
        addr_rs_id = 5'd3; addr_rt_id = 5'd3; rs_used_id = 1'b1; rt_used_id = 1'b1;
        #1;
        checks++; if ({fwd_a_ctrl, fwd_b_ctrl} !== 6'b001_001) begin
            errors++; $display("FAIL fwd_exe: got %b %b expected 001 001", fwd_a_ctrl, fwd_b_ctrl); end
        checks++; if ({if_en, id_en, exe_rst} !== 3'b110) begin
            errors++; $display("FAIL fwd_exe_nostall: got %b expected 110", {if_en, id_en, exe_rst}); end
        wb_wen_mem = 1'b1; regw_addr_mem = 5'd4; wb_wen_wb = 1'b1; regw_addr_wb = 5'd5;
        addr_rs_id = 5'd4; addr_rt_id = 5'd5;
        #1;
        checks++; if ({fwd_a_ctrl, fwd_b_ctrl} !== 6'b010_100) begin
            errors++; $display("FAIL fwd_mem_wb: got %b %b expected 010 100", fwd_a_ctrl, fwd_b_ctrl); end
        regw_addr_mem = 5'd3; regw_addr_wb = 5'd3; addr_rs_id = 5'd3; addr_rt_id = 5'd3; rt_used_id = 1'b0;
        #1;
        checks++; if ({fwd_a_ctrl, fwd_b_ctrl} !== 6'b001_000) begin
            errors++; $display("FAIL fwd_priority_unused: got %b %b expected 001 000", fwd_a_ctrl, fwd_b_ctrl); end
        regw_addr_exe = 5'd0; regw_addr_mem = 5'd0; regw_addr_wb = 5'd0;
        addr_rs_id = 5'd0; addr_rt_id = 5'd0; rt_used_id = 1'b1;
        #1;
        checks++; if ({fwd_a_ctrl, fwd_b_ctrl} !== 6'b000_000) begin
            errors++; $display("FAIL fwd_r0: got %b %b expected 000 000", fwd_a_ctrl, fwd_b_ctrl); end
        wb_wen_exe = 1'b0; mem_ren_mem = 1'b1; regw_addr_mem = 5'd6; regw_addr_wb = 5'd6;
        addr_rs_id = 5'd6; addr_rt_id = 5'd9;
        #1;
        checks++; if ({fwd_a_ctrl, fwd_b_ctrl} !== 6'b011_000) begin
            errors++; $display("FAIL fwd_mem_load: got %b %b expected 011 000", fwd_a_ctrl, fwd_b_ctrl); end
    endtask

    task automatic test_load_use;
        do_reset();
        wb_wen_exe = 1'b1; mem_ren_exe = 1'b1; regw_addr_exe = 5'd5;
        addr_rs_id = 5'd5; rs_used_id = 1'b1; addr_rt_id = 5'd0; rt_used_id = 1'b1;
        #1;
        checks++; if ({if_en, id_en, exe_rst, busy} !== 4'b0010) begin
            errors++; $display("FAIL load_stall_c1: got %b expected 0010", {if_en, id_en, exe_rst, busy}); end
        step();
        wb_wen_exe = 1'b0; mem_ren_exe = 1'b0; regw_addr_exe = 5'd0;
        wb_wen_mem = 1'b1; mem_ren_mem = 1'b1; regw_addr_mem = 5'd5;
        #1;
        checks++; if ({if_en, id_en, exe_rst, busy} !== 4'b0011) begin
            errors++; $display("FAIL load_stall_c2: got %b expected 0011", {if_en, id_en, exe_rst, busy}); end
        checks++; if ({z_if_en, z_id_en, z_exe_rst, z_busy} !== 4'b1100) begin
            errors++; $display("FAIL load_lat1_done: got %b expected 1100", {z_if_en, z_id_en, z_exe_rst, z_busy}); end
        step();
        checks++; if ({fwd_a_ctrl, if_en, id_en, exe_rst, busy} !== 7'b011_1100) begin
            errors++; $display("FAIL load_resume: got %b expected 0111100", {fwd_a_ctrl, if_en, id_en, exe_rst, busy}); end
        checks++; if (stall_load_cnt !== (PERF ? 32'd2 : 32'd0)) begin
            errors++; $display("FAIL stall_load_cnt: got %0d expected %0d", stall_load_cnt, PERF ? 2 : 0); end
        checks++; if (z_stall_load_cnt !== (PERF ? 4'd1 : 4'd0)) begin
            errors++; $display("FAIL stall_load_cnt_lat1: got %0d expected %0d", z_stall_load_cnt, PERF ? 1 : 0); end
    endtask

    task automatic test_store_fwd;
        do_reset();
        wb_wen_exe = 1'b1; mem_ren_exe = 1'b1; regw_addr_exe = 5'd7;
        is_store_id = 1'b1; addr_rt_id = 5'd7; rt_used_id = 1'b1; addr_rs_id = 5'd1; rs_used_id = 1'b1;
        #1;
        checks++; if ({fwd_m, exe_rst, if_en, id_en} !== 4'b1011) begin
            errors++; $display("FAIL store_fwd_m: got %b expected 1011", {fwd_m, exe_rst, if_en, id_en}); end
        step();
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL store_nobusy: got %b expected 0", busy); end
        regw_addr_exe = 5'd0; addr_rt_id = 5'd0;
        #1;
        checks++; if (fwd_m !== 1'b0) begin
            errors++; $display("FAIL store_r0: got %b expected 0", fwd_m); end
        regw_addr_exe = 5'd7; addr_rt_id = 5'd7; is_store_id = 1'b0;
        #1;
        checks++; if ({fwd_m, exe_rst} !== 2'b01) begin
            errors++; $display("FAIL nonstore_rt_stall: got %b expected 01", {fwd_m, exe_rst}); end
    endtask

    task automatic test_multi;
        do_reset();
        is_multi_id = 1'b1;
        #1;
        checks++; if ({id_en, exe_en, mem_rst, busy} !== 4'b1100) begin
            errors++; $display("FAIL multi_issue: got %b expected 1100", {id_en, exe_en, mem_rst, busy}); end
        step();
        is_multi_id = 1'b0; branch_taken_id = 1'b1;
        wb_wen_exe = 1'b1; mem_ren_exe = 1'b1; regw_addr_exe = 5'd5; addr_rs_id = 5'd5; rs_used_id = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({busy, if_en, id_en, exe_en, mem_rst, exe_rst, id_rst} !== 7'b1000100) begin
                errors++; $display("FAIL multi_busy_c%0d: got %b expected 1000100", i,
                                   {busy, if_en, id_en, exe_en, mem_rst, exe_rst, id_rst}); end
            step();
        end
        checks++; if ({busy, exe_rst, id_rst} !== 3'b010) begin
            errors++; $display("FAIL multi_return: got %b expected 010", {busy, exe_rst, id_rst}); end
        checks++; if (stall_multi_cnt !== (PERF ? 32'd3 : 32'd0)) begin
            errors++; $display("FAIL stall_multi_cnt: got %0d expected %0d", stall_multi_cnt, PERF ? 3 : 0); end
    endtask

    task automatic test_branch;
        do_reset();
        branch_taken_id = 1'b1;
        #1;
        checks++; if ({id_rst, busy} !== 2'b00) begin
            errors++; $display("FAIL branch_issue: got %b expected 00", {id_rst, busy}); end
        step();
        branch_taken_id = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({id_rst, if_en, busy, z_id_rst, z_busy} !== 5'b11100) begin
                errors++; $display("FAIL flush_c%0d: got %b expected 11100", i, {id_rst, if_en, busy, z_id_rst, z_busy}); end
            step();
        end
        checks++; if ({id_rst, busy} !== 2'b00) begin
            errors++; $display("FAIL flush_end: got %b expected 00", {id_rst, busy}); end
        checks++; if (flush_cnt !== (PERF ? 32'd2 : 32'd0) || z_flush_cnt !== 4'd0) begin
            errors++; $display("FAIL flush_cnt: got %0d/%0d expected %0d/0", flush_cnt, z_flush_cnt, PERF ? 2 : 0); end
        do_reset();
        branch_taken_id = 1'b1;
        wb_wen_exe = 1'b1; mem_ren_exe = 1'b1; regw_addr_exe = 5'd8; addr_rs_id = 5'd8; rs_used_id = 1'b1;
        step();
        wb_wen_exe = 1'b0; mem_ren_exe = 1'b0; regw_addr_exe = 5'd0;
        #1;
        checks++; if ({busy, id_rst, exe_rst} !== 3'b101) begin
            errors++; $display("FAIL branch_held: got %b expected 101", {busy, id_rst, exe_rst}); end
        branch_taken_id = 1'b0;
        step();
        step();
        checks++; if ({busy, id_rst} !== 2'b00) begin
            errors++; $display("FAIL branch_ignored: got %b expected 00", {busy, id_rst}); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        is_multi_id = 1'b1;
        step();
        is_multi_id = 1'b0;
        step();
        checks++; if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_pre_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if ({if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en, busy} !== 11'b11111111110) begin
            errors++; $display("FAIL mid_reset_async: got %b expected 11111111110",
                               {if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en, busy}); end
        checks++; if (stall_multi_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_reset_cnt: got %0d expected 0", stall_multi_cnt); end
        #1;
        rst = 1'b0;
        step();
        checks++; if ({busy, if_rst, id_rst, exe_rst, mem_rst, wb_rst, exe_en} !== 7'b0000001) begin
            errors++; $display("FAIL mid_release: got %b expected 0000001", {busy, if_rst, id_rst, exe_rst, mem_rst, wb_rst, exe_en}); end
        step();
        checks++; if ({busy, stall_multi_cnt} !== 33'd0) begin
            errors++; $display("FAIL mid_no_resume: got busy=%b cnt=%0d expected 0 0", busy, stall_multi_cnt); end
    endtask

    task automatic test_saturate;
        do_reset();
        wb_wen_exe = 1'b1; mem_ren_exe = 1'b1; regw_addr_exe = 5'd5; addr_rs_id = 5'd5; rs_used_id = 1'b1;
        repeat (20) step();
        checks++; if (z_stall_load_cnt !== (PERF ? 4'hf : 4'h0)) begin
            errors++; $display("FAIL sat_cnt: got %0d expected %0d", z_stall_load_cnt, PERF ? 15 : 0); end
        checks++; if (stall_load_cnt !== (PERF ? 32'd20 : 32'd0)) begin
            errors++; $display("FAIL wide_cnt: got %0d expected %0d", stall_load_cnt, PERF ? 20 : 0); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_store_fwd();
        test_multi();
        test_branch();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It is the successor to the single-cycle load-stall logic and is decoupled from instruction decode: the decoder supplies register-use flags. It adds a 3-bit forwarding select that includes WB, configurable load-use bubble count, a busy counter for multi-cycle EXE ops, and an optional taken-branch flush window. It drives the per-stage en/rst pairs of the IF/ID/EXE/MEM/WB registers.

Parameters:
REG_ADDR_W, 5, register address width
LOAD_LAT, 1, bubbles inserted on a load-use hazard (1..7)
MULTI_LAT, 4, EXE cycles of a multi-cycle op (1..15); 1 means no extra hold
BRANCH_FLUSH, 0, ID flush cycles after a taken branch; 0 means delay-slot semantics, no flush
CNT_W, 32, performance counter width

Ports:
clk  in  1  main clock
rst  in  1  reset, asynchronous, active-high
addr_rs_id  in  REG_ADDR_W  rs of instruction in ID
addr_rt_id  in  REG_ADDR_W  rt of instruction in ID
rs_used_id  in  1  ID reads rs
rt_used_id  in  1  ID reads rt
is_store_id  in  1  ID is a store (rt is memory data only)
is_multi_id  in  1  ID needs multi-cycle EXE
branch_taken_id  in  1  ID branch/jump resolved taken
wb_wen_exe  in  1  EXE writes a register
regw_addr_exe  in  REG_ADDR_W  EXE destination
mem_ren_exe  in  1  EXE is a load
wb_wen_mem  in  1  MEM writes a register
regw_addr_mem  in  REG_ADDR_W  MEM destination
mem_ren_mem  in  1  MEM is a load
wb_wen_wb  in  1  WB writes a register
regw_addr_wb  in  REG_ADDR_W  WB destination
fwd_a_ctrl  out  3  operand A source
fwd_b_ctrl  out  3  operand B source
fwd_m  out  1  store data forwarded from MEM load data
if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables
if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  stage synchronous clears
busy  out  1  state != RUN
stall_load_cnt, stall_multi_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Forwarding (combinational), per operand, used flag set, address != 0, first match wins:
  - EXE non-load: 3'b001
  - MEM load: 3'b011
  - MEM ALU result: 3'b010
  - WB: 3'b100
  - otherwise: 3'b000 (register file)
- Unused operands output 3'b000.
- fwd_m=1 when is_store_id, rt matches a load in EXE, and address != 0. No stall in that case.
- Load-use hazard: mem_ren_exe with address != 0 matching (rs_used_id && rs) or (rt_used_id && !is_store_id && rt).
- FSM states RUN, LOAD_STALL, MULTI_BUSY, FLUSH; counter cnt of 4 bits.
- RUN, priority load-use > multi > branch:
  - Load-use: hold IF/ID (en=0), exe_rst=1 this cycle. If LOAD_LAT>1, go to LOAD_STALL with cnt=LOAD_LAT-1.
  - ID advancing with is_multi_id and MULTI_LAT>1: go to MULTI_BUSY with cnt=MULTI_LAT-1.
  - ID advancing with branch_taken_id and BRANCH_FLUSH>0: go to FLUSH with cnt=BRANCH_FLUSH.
- LOAD_STALL: if_en=id_en=0, exe_rst=1, cnt--. At cnt==1, return to RUN next cycle.
- MULTI_BUSY: if_en=id_en=exe_en=0, mem_rst=1, cnt--. At cnt==1, return to RUN. Hazards in ID are re-evaluated only in RUN.
- FLUSH: id_rst=1 and IF enabled each cycle, cnt--. At cnt==1, return to RUN.
- branch_taken_id is ignored whenever ID is held.
- Defaults: all en=1, all rst=0.
- rst asserted:
  - All *_rst=1, all en=1.
  - State=RUN, cnt=0, busy=0, counters=0, immediately (async), including mid-stall.
- Counters saturate at all-ones; they count cycles spent stalling or flushing. The first load-use cycle in RUN counts.

Optional Feature:
HAZ_PERF_CNT_EN: when defined, stall_load_cnt / stall_multi_cnt / flush_cnt increment as above. When undefined, the counter registers are not built and the three outputs are tied to 0. Hazard, forwarding and FSM behaviour are identical either way.

Test Plan:
- EXE add writes r3; ID add r4,r3,r3 -> fwd_a_ctrl=fwd_b_ctrl=3'b001, no stall.
- EXE lw r5; ID add r6,r5,r0 with LOAD_LAT=2 -> two cycles if_en=id_en=0, exe_rst=1; then fwd_a_ctrl=3'b011 on the next cycle; stall_load_cnt=2.
- EXE lw r7; ID sw r7,0(r1) -> fwd_m=1, no stall, exe_rst=0.
- ID is_multi_id, MULTI_LAT=4 -> busy=1 for 3 cycles with exe_en=0, mem_rst=1, then RUN; stall_multi_cnt=3.
- BRANCH_FLUSH=2, branch_taken_id with ID advancing -> id_rst=1 for 2 cycles; with BRANCH_FLUSH=0 -> id_rst stays 0.
- rst pulsed mid MULTI_BUSY (cnt=2) -> same cycle: all *_rst=1, busy=0; after release: state RUN, counters 0.
